// File: rtl/text_console_ctrl.sv
// text_console_ctrl: command engine for the VGA text console.
// Accepts SCROLL / CLEAR_FIELD / NUMBER / CLEAR_ALL (and optionally HEX) commands over a
// valid/ready handshake and emits one registered character-cell write per cycle.
// NUMBER converts a signed 32-bit value to decimal with an iterative double-dabble
// (32 shift-add-3 cycles) before the field is written.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is combinational (IDLE and not rst)
//   cmd, cmd_data          opcode and {fg[11:0], bg[11:0], x[15:0], y[15:0], num[31:0]}
//   wr_en/wr_x/wr_y        character-buffer write strobe and physical cell address
//   wr_value               {fg[11:0], bg[11:0], char[7:0]}
//   offset                 scroll offset (physical row of logical row 0)
// Optional feature: define TEXT_CONSOLE_HEX_EN to enable opcode 5 (unsigned hex print).
module text_console_ctrl #(
  parameter int unsigned COLS   = 160,
  parameter int unsigned ROWS   = 45,
  parameter int unsigned DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic [3:0]              cmd,
  input  logic [87:0]             cmd_data,
  output logic                    cmd_ready,
  output logic                    wr_en,
  output logic [$clog2(COLS)-1:0] wr_x,
  output logic [$clog2(ROWS)-1:0] wr_y,
  output logic [31:0]             wr_value,
  output logic [$clog2(ROWS)-1:0] offset
);
  localparam int unsigned XW      = $clog2(COLS);
  localparam int unsigned YW      = $clog2(ROWS);
  localparam int unsigned IW      = $clog2(DIGITS + 2);
  localparam int unsigned FIELD_W = DIGITS + 2;
  // 10 BCD digits always cover 2^31, so overflow is detectable for any DIGITS
  localparam int          BCD_N   = 10;

  typedef enum logic [2:0] {StIdle, StClrRow, StClrField, StConvert, StEmit, StClrAll} state_e;

  state_e            state_q, state_d;
  logic [YW-1:0]     offset_q, offset_d;
  logic [11:0]       fg_q, fg_d, bg_q, bg_d;
  logic              neg_q, neg_d;
  logic [XW-1:0]     col_q, col_d;
  logic [YW-1:0]     row_q, row_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4:0]        bit_q, bit_d;
  logic [31:0]       bin_q, bin_d;
  logic [4*BCD_N-1:0] bcd_q, bcd_d, bcd_adj;
  logic              wr_en_q, wr_en_d;
  logic [XW-1:0]     wr_x_q, wr_x_d;
  logic [YW-1:0]     wr_y_q, wr_y_d;
  logic [31:0]       wr_value_q, wr_value_d;
  logic [XW-1:0]     col_next;
  logic [7:0]        num_char, cell_char;
`ifdef TEXT_CONSOLE_HEX_EN
  logic              hex_q, hex_d;
  logic [31:0]       num_q, num_d;
  logic [7:0]        hex_char;
`endif

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign wr_en     = wr_en_q;
  assign wr_x      = wr_x_q;
  assign wr_y      = wr_y_q;
  assign wr_value  = wr_value_q;
  assign offset    = offset_q;

  assign col_next = (col_q == XW'(COLS - 1)) ? '0 : col_q + XW'(1);

  // Decimal character for field cell idx_q; digit position p counts from the units cell.
  always_comb begin : num_cell
    int nd;
    int p;
    logic [3:0] dig;
    nd = 1;
    for (int k = 0; k < BCD_N; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) nd = k + 1;
    end
    p   = int'(DIGITS) - int'(idx_q);
    dig = 4'd0;
    for (int k = 0; k < BCD_N; k++) begin
      if (k == p) dig = bcd_q[4*k +: 4];
    end
    if (nd > int'(DIGITS))      num_char = 8'h23;
    else if (p < nd)            num_char = 8'h30 + {4'd0, dig};
    else if (neg_q && p == nd)  num_char = 8'h2D;
    else                        num_char = 8'h20;
  end

`ifdef TEXT_CONSOLE_HEX_EN
  always_comb begin : hex_cell
    int p;
    logic [3:0] nib;
    p   = int'(DIGITS) - int'(idx_q);
    nib = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (k == p) nib = num_q[4*k +: 4];
    end
    if (DIGITS < 8)             hex_char = 8'h23;
    else if (p < 8)             hex_char = (nib < 4'd10) ? 8'h30 + {4'd0, nib}
                                                         : 8'h37 + {4'd0, nib};
    else                        hex_char = 8'h20;
  end
  assign cell_char = hex_q ? hex_char : num_char;
`else
  assign cell_char = num_char;
`endif

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    neg_d      = neg_q;
    col_d      = col_q;
    row_d      = row_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    wr_en_d    = 1'b0;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_value_d = wr_value_q;
`ifdef TEXT_CONSOLE_HEX_EN
    hex_d      = hex_q;
    num_d      = num_q;
`endif
    // add-3 step of double dabble, applied before each shift
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_N; k++) begin
      if (bcd_adj[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          fg_d  = cmd_data[87:76];
          bg_d  = cmd_data[75:64];
          neg_d = cmd_data[31];
          row_d = YW'((32'(cmd_data[47:32]) + 32'(offset_q)) % ROWS);
          col_d = XW'((32'(cmd_data[63:48]) * FIELD_W) % COLS);
          idx_d = '0;
`ifdef TEXT_CONSOLE_HEX_EN
          hex_d = 1'b0;
          num_d = cmd_data[31:0];
`endif
          case (cmd)
            4'd1: begin
              offset_d = (offset_q == YW'(ROWS - 1)) ? '0 : offset_q + YW'(1);
              row_d    = offset_q;
              col_d    = XW'(COLS - 1);
              state_d  = StClrRow;
            end
            4'd2: state_d = StClrField;
            4'd3: begin
              bin_d   = cmd_data[31] ? (~cmd_data[31:0] + 32'd1) : cmd_data[31:0];
              bcd_d   = '0;
              bit_d   = '0;
              state_d = StConvert;
            end
            4'd4: begin
              offset_d = '0;
              row_d    = '0;
              col_d    = '0;
              state_d  = StClrAll;
            end
`ifdef TEXT_CONSOLE_HEX_EN
            4'd5: begin
              hex_d   = 1'b1;
              state_d = StEmit;
            end
`endif
            default: ;
          endcase
        end
      end
      StClrRow: begin
        wr_en_d    = 1'b1;
        wr_x_d     = col_q;
        wr_y_d     = row_q;
        wr_value_d = '0;
        col_d      = col_q - XW'(1);
        if (col_q == '0) state_d = StIdle;
      end
      StClrField: begin
        wr_en_d    = 1'b1;
        wr_x_d     = col_q;
        wr_y_d     = row_q;
        wr_value_d = '0;
        col_d      = col_next;
        idx_d      = idx_q + IW'(1);
        if (idx_q == IW'(DIGITS)) state_d = StIdle;
      end
      StConvert: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        bit_d          = bit_q + 5'd1;
        if (bit_q == 5'd31) state_d = StEmit;
      end
      StEmit: begin
        wr_en_d    = 1'b1;
        wr_x_d     = col_q;
        wr_y_d     = row_q;
        wr_value_d = {fg_q, bg_q, cell_char};
        col_d      = col_next;
        idx_d      = idx_q + IW'(1);
        if (idx_q == IW'(DIGITS)) state_d = StIdle;
      end
      StClrAll: begin
        wr_en_d    = 1'b1;
        wr_x_d     = col_q;
        wr_y_d     = row_q;
        wr_value_d = '0;
        if (col_q == XW'(COLS - 1)) begin
          col_d = '0;
          if (row_q == YW'(ROWS - 1)) state_d = StIdle;
          else                        row_d   = row_q + YW'(1);
        end else begin
          col_d = col_q + XW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      offset_q   <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      neg_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      bit_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_value_q <= '0;
`ifdef TEXT_CONSOLE_HEX_EN
      hex_q      <= 1'b0;
      num_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      neg_q      <= neg_d;
      col_q      <= col_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      bit_q      <= bit_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_value_q <= wr_value_d;
`ifdef TEXT_CONSOLE_HEX_EN
      hex_q      <= hex_d;
      num_q      <= num_d;
`endif
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: main instance with default parameters plus a
// DIGITS=4 instance for the overflow field. Writes are checked against a queue of expected
// cell writes built from an independent arithmetic model.
module tb_text_console_ctrl;
  localparam int COLS   = 160;
  localparam int ROWS   = 45;
  localparam int DIGITS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [3:0]  cmd;
  logic [87:0] cmd_data;
  logic        cmd_ready, wr_en;
  logic [7:0]  wr_x;
  logic [5:0]  wr_y, offset;
  logic [31:0] wr_value;

  logic        c2_valid;
  logic [3:0]  c2_cmd;
  logic [87:0] c2_data;
  logic        c2_ready, c2_wr_en;
  logic [7:0]  c2_x;
  logic [5:0]  c2_y, c2_off;
  logic [31:0] c2_value;

  always #5 clk = ~clk;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .DIGITS(DIGITS)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_value(wr_value),
    .offset(offset)
  );

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd(c2_cmd), .cmd_data(c2_data),
    .cmd_ready(c2_ready), .wr_en(c2_wr_en), .wr_x(c2_x), .wr_y(c2_y), .wr_value(c2_value),
    .offset(c2_off)
  );

  typedef struct packed {
    logic [7:0]  x;
    logic [5:0]  y;
    logic [31:0] v;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors  = 0;
  int  checks  = 0;
  int  nwrites = 0;
  bit  mon_en  = 1'b1;
  int  exp_off = 0;

  // Decimal field model: cell i (0 = leftmost) of a DIGITS+1 wide field.
  function automatic logic [7:0] num_model(logic [31:0] n, int digits, int i);
    longint mag, t;
    int nd, p;
    mag = n[31] ? (64'sh1_0000_0000 - longint'({32'd0, n})) : longint'({32'd0, n});
    nd = 0;
    t  = mag;
    do begin nd++; t = t / 10; end while (t != 0);
    p = digits - i;
    if (nd > digits) return 8'h23;
    if (p < nd) begin
      t = mag;
      for (int k = 0; k < p; k++) t = t / 10;
      return 8'h30 + 8'(t % 10);
    end
    if (n[31] && p == nd) return 8'h2D;
    return 8'h20;
  endfunction

  function automatic logic [7:0] hex_model(logic [31:0] n, int digits, int i);
    int p;
    logic [3:0] nib;
    p = digits - i;
    if (digits < 8) return 8'h23;
    if (p >= 8) return 8'h20;
    nib = 4'(n >> (4 * p));
    return (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10;
  endfunction

  // kind: 0 clear, 1 decimal, 2 hex
  task automatic push_field(input int kind, input logic [11:0] fg, input logic [11:0] bg,
                            input int x, input int y, input logic [31:0] num);
    wr_t e;
    for (int i = 0; i <= DIGITS; i++) begin
      e.x = 8'((x * (DIGITS + 2) + i) % COLS);
      e.y = 6'((y + exp_off) % ROWS);
      if (kind == 0)      e.v = '0;
      else if (kind == 1) e.v = {fg, bg, num_model(num, DIGITS, i)};
      else                e.v = {fg, bg, hex_model(num, DIGITS, i)};
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [11:0] fg, input logic [11:0] bg,
                      input logic [15:0] x, input logic [15:0] y, input logic [31:0] num);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 10000) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL send_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd       = op;
    cmd_data  = {fg, bg, x, y, num};
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !cmd_ready) && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || !cmd_ready) begin
      errors++;
      $display("FAIL drain: pending=%0d ready=%0b required pending=0 ready=1",
               exp_q.size(), cmd_ready);
      exp_q.delete();
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && !rst && wr_en) begin
      checks++;
      nwrites++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x=%0d y=%0d v=%h, required no write",
                 wr_x, wr_y, wr_value);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wr_x, wr_y, wr_value} !== {mon_e.x, mon_e.y, mon_e.v}) begin
          errors++;
          $display("FAIL write#%0d: got x=%0d y=%0d v=%h, required x=%0d y=%0d v=%h",
                   nwrites, wr_x, wr_y, wr_value, mon_e.x, mon_e.y, mon_e.v);
        end
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({wr_en, wr_x, wr_y, wr_value} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b x=%0d y=%0d v=%h, required all 0",
               wr_en, wr_x, wr_y, wr_value);
    end
    checks++;
    if (offset !== 6'd0) begin errors++; $display("FAIL reset_offset: got %0d required 0", offset); end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_in_rst: got %0b required 0", cmd_ready);
    end
    checks++;
    if (c2_wr_en !== 1'b0) begin errors++; $display("FAIL reset_dut4_wr_en: got %0b required 0", c2_wr_en); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", cmd_ready); end
  endtask

  task automatic test_nop();
    logic [3:0] ops[2];
    ops[0] = 4'd0;
    ops[1] = 4'd7;
    for (int t = 0; t < 2; t++) begin
      send(ops[t], 12'hFFF, 12'h0, 16'd0, 16'd0, 32'd5);
      checks++;
      if (cmd_ready !== 1'b1 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL nop_op%0d: ready=%0b wr_en=%0b required ready=1 wr_en=0",
                 ops[t], cmd_ready, wr_en);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_hex();
`ifdef TEXT_CONSOLE_HEX_EN
    push_field(2, 12'hABC, 12'h123, 2, 4, 32'h0000BEEF);
    send(4'd5, 12'hABC, 12'h123, 16'd2, 16'd4, 32'h0000BEEF);
    @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL hex_latency: wr_en=%0b required 1", wr_en); end
    drain(50);
`else
    send(4'd5, 12'hABC, 12'h123, 16'd2, 16'd4, 32'h0000BEEF);
    checks++;
    if (cmd_ready !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL hex_disabled: ready=%0b wr_en=%0b required ready=1 wr_en=0", cmd_ready, wr_en);
    end
    repeat (5) @(negedge clk);
`endif
  endtask

  task automatic do_scroll();
    wr_t e;
    for (int c = COLS - 1; c >= 0; c--) begin
      e.x = 8'(c);
      e.y = 6'(exp_off);
      e.v = '0;
      exp_q.push_back(e);
    end
    send(4'd1, 12'h0, 12'h0, 16'd0, 16'd0, 32'd0);
    exp_off = (exp_off == ROWS - 1) ? 0 : exp_off + 1;
    checks++;
    if (offset !== 6'(exp_off)) begin
      errors++; $display("FAIL scroll_offset: got %0d required %0d", offset, exp_off);
    end
    drain(400);
  endtask

  task automatic test_scroll();
    for (int s = 0; s < ROWS; s++) do_scroll();
  endtask

  task automatic test_number();
    int n;
    logic [31:0] nums[3];
    int xs[3];
    int ys[3];
    repeat (3) do_scroll();
    push_field(1, 12'hFFF, 12'h000, 1, 0, 32'hFFFFFFD6);
    send(4'd3, 12'hFFF, 12'h000, 16'd1, 16'd0, 32'hFFFFFFD6);
    n = 0;
    while (!wr_en && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 33) begin errors++; $display("FAIL number_latency: got %0d cycles required 33", n); end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL number_busy: ready=%0b required 0", cmd_ready); end
    drain(100);
    nums[0] = 32'h80000000; xs[0] = 2;  ys[0] = 10;
    nums[1] = 32'd0;        xs[1] = 3;  ys[1] = 44;
    nums[2] = 32'd123456789; xs[2] = 13; ys[2] = 1;
    for (int t = 0; t < 3; t++) begin
      push_field(1, 12'h0F0, 12'h00F, xs[t], ys[t], nums[t]);
      send(4'd3, 12'h0F0, 12'h00F, 16'(xs[t]), 16'(ys[t]), nums[t]);
      drain(100);
    end
  endtask

  task automatic test_clear_field();
    int n, k, seen;
    push_field(0, 12'h0, 12'h0, 13, 5, 32'd0);
    send(4'd2, 12'hFFF, 12'hFFF, 16'd13, 16'd5, 32'd99);
    drain(50);
    // abort a second clear mid-field with reset
    mon_en = 1'b0;
    send(4'd2, 12'h0, 12'h0, 16'd13, 16'd5, 32'd0);
    n = 0;
    k = 0;
    while (k < 4 && n < 50) begin @(negedge clk); n++; if (wr_en) k++; end
    checks++;
    if (k !== 4) begin errors++; $display("FAIL clr_field_started: got %0d writes required 4", k); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en: got %0b required 0", wr_en); end
    checks++;
    if (offset !== 6'd0) begin errors++; $display("FAIL rst_mid_offset: got %0d required 0", offset); end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (wr_en) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_writes: got %0d writes required 0", seen); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b required 1", cmd_ready); end
    exp_off = 0;
    mon_en  = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    push_field(1, 12'h0F0, 12'h00F, 4, 7, 32'd987654);
    push_field(0, 12'h0, 12'h0, 5, 7, 32'd0);
    send(4'd3, 12'h0F0, 12'h00F, 16'd4, 16'd7, 32'd987654);
    cmd_valid = 1'b1;
    cmd       = 4'd2;
    cmd_data  = {12'h0, 12'h0, 16'd5, 16'd7, 32'd0};
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n !== 43) begin errors++; $display("FAIL b2b_held_cycles: got %0d required 43", n); end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain(100);
  endtask

  task automatic test_clear_all();
    wr_t e;
    repeat (2) do_scroll();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        e.x = 8'(c);
        e.y = 6'(r);
        e.v = '0;
        exp_q.push_back(e);
      end
    end
    send(4'd4, 12'hFFF, 12'hFFF, 16'd3, 16'd3, 32'd1);
    exp_off = 0;
    checks++;
    if (offset !== 6'd0) begin errors++; $display("FAIL clear_all_offset: got %0d required 0", offset); end
    drain(8000);
  endtask

  task automatic test_digits4();
    logic [31:0] nums[3];
    logic [31:0] ev;
    int n, k;
    nums[0] = 32'd12345;
    nums[1] = 32'hFFFFD8F1;
    nums[2] = 32'd7;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      c2_valid = 1'b1;
      c2_cmd   = 4'd3;
      c2_data  = {12'h111, 12'h222, 16'd1, 16'd2, nums[t]};
      @(posedge clk);
      #1 c2_valid = 1'b0;
      n = 0;
      k = 0;
      while (k < 5 && n < 100) begin
        @(negedge clk);
        n++;
        if (c2_wr_en) begin
          ev = {12'h111, 12'h222, num_model(nums[t], 4, k)};
          checks++;
          if ({c2_x, c2_y, c2_value} !== {8'(6 + k), 6'd2, ev}) begin
            errors++;
            $display("FAIL d4_cell%0d num=%h: got x=%0d y=%0d v=%h, required x=%0d y=2 v=%h",
                     k, nums[t], c2_x, c2_y, c2_value, 6 + k, ev);
          end
          k++;
        end
      end
      @(negedge clk);
      checks++;
      if (k !== 5 || c2_wr_en !== 1'b0 || c2_ready !== 1'b1) begin
        errors++;
        $display("FAIL d4_count num=%h: got %0d writes en=%0b ready=%0b, required 5 0 1",
                 nums[t], k, c2_wr_en, c2_ready);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = '0;
    cmd_data  = '0;
    c2_valid  = 1'b0;
    c2_cmd    = '0;
    c2_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_nop();
    test_hex();
    test_scroll();
    test_number();
    test_clear_field();
    test_back_to_back();
    test_clear_all();
    test_digits4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
